// File: rtl/cw305_usb_master_if.sv
// ----------------------------------------------------------------------------
// cw305_usb_master_if
//
// Purpose: groups the command, response and USB bus-side signals of
// cw305_usb_master so they can be passed as one port.
//
// Handshake: a command transfers on the rising usb_clk edge where
// cmd_valid_i and cmd_ready_o are both high; the offerer keeps the cmd_*
// fields stable while cmd_valid_i is high and not yet accepted, and
// rsp_valid_o is a single-cycle completion pulse with no back-pressure.
//
// Signals:
//   cmd_valid_i / cmd_ready_o         command handshake
//   cmd_write_i, cmd_addr_i,
//   cmd_wdata_i                       command direction / address / write byte
//   rsp_valid_o, rsp_rdata_o          completion pulse and last byte read
//   usb_addr_o, usb_dout_o, usb_din_i bus address and data
//   usb_drive_o                       data output enable
//   usb_cen_o, usb_rdn_o, usb_wrn_o   active-low bus strobes
//   cmd_trig_i, usb_trigger_o         only when USB_MASTER_TRIGGER_EN is defined
//
// Modports: master = the bus-master block, slave = whoever issues commands.
// ----------------------------------------------------------------------------
interface cw305_usb_master_if #(
    parameter int pADDR_WIDTH = 21
);
    logic                   cmd_valid_i;
    logic                   cmd_ready_o;
    logic                   cmd_write_i;
    logic [pADDR_WIDTH-1:0] cmd_addr_i;
    logic [7:0]             cmd_wdata_i;

    logic                   rsp_valid_o;
    logic [7:0]             rsp_rdata_o;

    logic [pADDR_WIDTH-1:0] usb_addr_o;
    logic [7:0]             usb_dout_o;
    logic [7:0]             usb_din_i;
    logic                   usb_drive_o;
    logic                   usb_cen_o;
    logic                   usb_rdn_o;
    logic                   usb_wrn_o;

`ifdef USB_MASTER_TRIGGER_EN
    logic                   cmd_trig_i;
    logic                   usb_trigger_o;
`endif

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, usb_din_i,
`ifdef USB_MASTER_TRIGGER_EN
        input  cmd_trig_i,
        output usb_trigger_o,
`endif
        output cmd_ready_o, rsp_valid_o, rsp_rdata_o, usb_addr_o, usb_dout_o,
               usb_drive_o, usb_cen_o, usb_rdn_o, usb_wrn_o
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, usb_din_i,
`ifdef USB_MASTER_TRIGGER_EN
        output cmd_trig_i,
        input  usb_trigger_o,
`endif
        input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, usb_addr_o, usb_dout_o,
               usb_drive_o, usb_cen_o, usb_rdn_o, usb_wrn_o
    );
endinterface

// File: rtl/cw305_usb_master.sv
// ----------------------------------------------------------------------------
// cw305_usb_master
//
// Purpose: turns single-byte read/write commands into a CW305 USB bus cycle
// with programmable setup / strobe / hold lengths:
//   accept -> SETUP (cen low, address valid, data driven on writes)
//          -> STROBE (wrn or rdn low; read data captured on its last edge)
//          -> HOLD (address and cen held) -> IDLE with a one-cycle rsp_valid.
//
// Parameters:
//   pADDR_WIDTH    bus address width
//   pSETUP_CYCLES  cycles of address before the strobe (1..255)
//   pSTROBE_CYCLES cycles the strobe is low (1..255)
//   pHOLD_CYCLES   cycles of address/cen after the strobe (1..255)
//
// Ports:
//   usb_clk    sole clock, rising edge
//   reset_i    asynchronous active-high reset
//   bus        cw305_usb_master_if master modport (command, response, bus)
//   dbg_state  current FSM state (0 IDLE, 1 SETUP, 2 STROBE, 3 HOLD)
//
// Optional feature: define USB_MASTER_TRIGGER_EN to add cmd_trig_i and
// usb_trigger_o (high during the STROBE cycles of a triggered write).
// ----------------------------------------------------------------------------
module cw305_usb_master #(
    parameter int pADDR_WIDTH    = 21,
    parameter int pSETUP_CYCLES  = 1,
    parameter int pSTROBE_CYCLES = 2,
    parameter int pHOLD_CYCLES   = 1
) (
    input  logic                usb_clk,
    input  logic                reset_i,
    cw305_usb_master_if.master  bus,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // The counter is loaded with length-1 on entry; the state exits on the
    // edge where it reads zero, giving exactly "length" cycles per state.
    localparam logic [7:0] SETUP_RELOAD  = 8'(pSETUP_CYCLES - 1);
    localparam logic [7:0] STROBE_RELOAD = 8'(pSTROBE_CYCLES - 1);
    localparam logic [7:0] HOLD_RELOAD   = 8'(pHOLD_CYCLES - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       is_write;
`ifdef USB_MASTER_TRIGGER_EN
    logic       trig_q;
`endif

    // Ready is combinational so that a command can be taken on the very first
    // edge after reset releases, and so it drops as soon as reset asserts.
    assign bus.cmd_ready_o = (state == IDLE) && !reset_i;
    assign dbg_state       = state;

    always_ff @(posedge usb_clk or posedge reset_i) begin
        if (reset_i) begin
            state           <= IDLE;
            cnt             <= 8'd0;
            is_write        <= 1'b0;
            bus.rsp_valid_o <= 1'b0;
            bus.rsp_rdata_o <= 8'd0;
            bus.usb_addr_o  <= {pADDR_WIDTH{1'b0}};
            bus.usb_dout_o  <= 8'd0;
            bus.usb_drive_o <= 1'b0;
            bus.usb_cen_o   <= 1'b1;
            bus.usb_rdn_o   <= 1'b1;
            bus.usb_wrn_o   <= 1'b1;
`ifdef USB_MASTER_TRIGGER_EN
            trig_q            <= 1'b0;
            bus.usb_trigger_o <= 1'b0;
`endif
        end else begin
            // rsp_valid is only ever set on the HOLD->IDLE edge, so clearing
            // it here makes it a one-cycle pulse.
            bus.rsp_valid_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.cmd_valid_i) begin
                        state          <= SETUP;
                        cnt            <= SETUP_RELOAD;
                        is_write       <= bus.cmd_write_i;
                        bus.usb_addr_o <= bus.cmd_addr_i;
                        bus.usb_cen_o  <= 1'b0;
                        // On reads the data bus keeps its previous byte and
                        // stays undriven.
                        if (bus.cmd_write_i) begin
                            bus.usb_dout_o  <= bus.cmd_wdata_i;
                            bus.usb_drive_o <= 1'b1;
                        end
`ifdef USB_MASTER_TRIGGER_EN
                        trig_q <= bus.cmd_trig_i;
`endif
                    end
                end

                SETUP: begin
                    if (cnt == 8'd0) begin
                        state <= STROBE;
                        cnt   <= STROBE_RELOAD;
                        if (is_write) begin
                            bus.usb_wrn_o <= 1'b0;
                        end else begin
                            bus.usb_rdn_o <= 1'b0;
                        end
`ifdef USB_MASTER_TRIGGER_EN
                        bus.usb_trigger_o <= is_write && trig_q;
`endif
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                STROBE: begin
                    if (cnt == 8'd0) begin
                        state         <= HOLD;
                        cnt           <= HOLD_RELOAD;
                        bus.usb_wrn_o <= 1'b1;
                        bus.usb_rdn_o <= 1'b1;
                        // Read data is sampled on the edge that ends the strobe.
                        if (!is_write) begin
                            bus.rsp_rdata_o <= bus.usb_din_i;
                        end
`ifdef USB_MASTER_TRIGGER_EN
                        bus.usb_trigger_o <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                HOLD: begin
                    if (cnt == 8'd0) begin
                        state           <= IDLE;
                        bus.usb_cen_o   <= 1'b1;
                        bus.usb_drive_o <= 1'b0;
                        bus.rsp_valid_o <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cw305_usb_master.sv
// ----------------------------------------------------------------------------
// tb_cw305_usb_master
//
// Directed bench for cw305_usb_master at default timing (S=1, P=2, H=1).
// Outputs are sampled 1 time unit after each rising edge. A transaction
// accepted on edge N shows SETUP after N, STROBE after N+1 and N+2, HOLD
// after N+3 and the rsp_valid pulse after N+4 (the 5th cycle from accept).
// ----------------------------------------------------------------------------
module tb_cw305_usb_master;

    localparam int AW = 21;

    // ---------------- clock / reset ----------------
    logic       usb_clk;
    logic       reset_i;
    logic [1:0] dbg_state;

    initial usb_clk = 1'b0;
    always #5 usb_clk = ~usb_clk;

    cw305_usb_master_if #(.pADDR_WIDTH(AW)) bus ();

    cw305_usb_master #(.pADDR_WIDTH(AW)) dut (
        .usb_clk   (usb_clk),
        .reset_i   (reset_i),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int         n_cmp;
    int         n_err;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge usb_clk);
        #1;
    endtask

    task automatic offer(input logic wr, input logic [AW-1:0] addr, input logic [7:0] wdata);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = wr;
        bus.cmd_addr_i  = addr;
        bus.cmd_wdata_i = wdata;
    endtask

    // Counts edges from the SETUP sample until rsp_valid is seen; bounded.
    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        while (bus.rsp_valid_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, n, 4);
    endtask

    logic [7:0] exp_b;

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        reset_i         = 1'b0;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_write_i = 1'b0;
        bus.cmd_addr_i  = '0;
        bus.cmd_wdata_i = 8'h00;
        bus.usb_din_i   = 8'h00;
`ifdef USB_MASTER_TRIGGER_EN
        bus.cmd_trig_i  = 1'b0;
`endif
        #1 reset_i = 1'b1;
        #1;
        // Reset values, checked before any clock edge.
        chk("rst_ready", bus.cmd_ready_o, 0);
        chk("rst_cen",   bus.usb_cen_o, 1);
        chk("rst_rdn",   bus.usb_rdn_o, 1);
        chk("rst_wrn",   bus.usb_wrn_o, 1);
        chk("rst_drive", bus.usb_drive_o, 0);
        chk("rst_rspv",  bus.rsp_valid_o, 0);
        chk("rst_addr",  bus.usb_addr_o, 0);
        chk("rst_dout",  bus.usb_dout_o, 0);
        chk("rst_rdata", bus.rsp_rdata_o, 0);
        chk("rst_state", dbg_state, 0);
        tick();
        tick();
        reset_i = 1'b0;
        #1;
        chk("idle_ready", bus.cmd_ready_o, 1);

        // ---- write 0x00041 <- 0xA5 ----
        offer(1'b1, 21'h00041, 8'hA5);
        tick();
        bus.cmd_valid_i = 1'b0;
        bus.cmd_addr_i  = 21'h1FFFF;   // must be ignored while busy
        bus.cmd_wdata_i = 8'hFF;
        chk("wr_setup_cen",   bus.usb_cen_o, 0);
        chk("wr_setup_drive", bus.usb_drive_o, 1);
        chk("wr_setup_dout",  bus.usb_dout_o, 8'hA5);
        chk("wr_setup_addr",  bus.usb_addr_o, 21'h00041);
        chk("wr_setup_wrn",   bus.usb_wrn_o, 1);
        chk("wr_setup_ready", bus.cmd_ready_o, 0);
        chk("wr_setup_state", dbg_state, 1);
        tick();
        chk("wr_strobe1_wrn", bus.usb_wrn_o, 0);
        chk("wr_strobe1_rdn", bus.usb_rdn_o, 1);
        chk("wr_strobe1_state", dbg_state, 2);
        tick();
        chk("wr_strobe2_wrn", bus.usb_wrn_o, 0);
        chk("wr_strobe2_addr", bus.usb_addr_o, 21'h00041);
        tick();
        chk("wr_hold_wrn", bus.usb_wrn_o, 1);
        chk("wr_hold_cen", bus.usb_cen_o, 0);
        chk("wr_hold_rspv", bus.rsp_valid_o, 0);
        tick();
        chk("wr_rspv",    bus.rsp_valid_o, 1);
        chk("wr_idle_cen", bus.usb_cen_o, 1);
        chk("wr_idle_drive", bus.usb_drive_o, 0);
        chk("wr_idle_addr", bus.usb_addr_o, 21'h00041);
        chk("wr_idle_dout", bus.usb_dout_o, 8'hA5);
        chk("wr_rdata_unchanged", bus.rsp_rdata_o, 0);
        tick();
        chk("wr_rspv_one_cycle", bus.rsp_valid_o, 0);

        // ---- read 0x00080, din 0x3C ----
        offer(1'b0, 21'h00080, 8'h00);
        exp_q.push_back(8'h3C);
        tick();
        bus.cmd_valid_i = 1'b0;
        bus.usb_din_i   = 8'h3C;
        chk("rd_setup_cen",   bus.usb_cen_o, 0);
        chk("rd_setup_drive", bus.usb_drive_o, 0);
        chk("rd_setup_rdn",   bus.usb_rdn_o, 1);
        tick();
        chk("rd_strobe1_rdn", bus.usb_rdn_o, 0);
        chk("rd_strobe1_wrn", bus.usb_wrn_o, 1);
        chk("rd_strobe1_drive", bus.usb_drive_o, 0);
        tick();
        chk("rd_strobe2_rdn", bus.usb_rdn_o, 0);
        chk("rd_strobe2_rdata_old", bus.rsp_rdata_o, 0);
        tick();
        chk("rd_hold_rdn", bus.usb_rdn_o, 1);
        chk("rd_hold_drive", bus.usb_drive_o, 0);
        tick();
        chk("rd_rspv", bus.rsp_valid_o, 1);
        exp_b = exp_q.pop_front();
        chk("rd_rdata", bus.rsp_rdata_o, exp_b);
        chk("rd_addr", bus.usb_addr_o, 21'h00080);
        chk("rd_dout_kept", bus.usb_dout_o, 8'hA5);
        bus.usb_din_i = 8'h00;
        tick();

        // ---- back-to-back: write 0x00123 <- 0x5A then read 0x00007 ----
        offer(1'b1, 21'h00123, 8'h5A);
        tick();
        offer(1'b0, 21'h00007, 8'h00);   // valid held high throughout
        wait_rsp("b2b_wr_latency");
        chk("b2b_wr_rdata_kept", bus.rsp_rdata_o, 8'h3C);
        chk("b2b_gap_cen", bus.usb_cen_o, 1);
        chk("b2b_gap_ready", bus.cmd_ready_o, 1);
        bus.usb_din_i = 8'h99;
        exp_q.push_back(8'h99);
        tick();
        bus.cmd_valid_i = 1'b0;
        chk("b2b_rd_accept_cen", bus.usb_cen_o, 0);
        chk("b2b_rd_addr", bus.usb_addr_o, 21'h00007);
        chk("b2b_rd_dout_kept", bus.usb_dout_o, 8'h5A);
        wait_rsp("b2b_rd_latency");
        exp_b = exp_q.pop_front();
        chk("b2b_rd_rdata", bus.rsp_rdata_o, exp_b);
        tick();

        // ---- reset during STROBE of a write ----
        offer(1'b1, 21'h00055, 8'h11);
        tick();
        bus.cmd_valid_i = 1'b0;
        tick();
        chk("abort_strobe_wrn", bus.usb_wrn_o, 0);
        #2 reset_i = 1'b1;
        #1;
        chk("abort_wrn",   bus.usb_wrn_o, 1);
        chk("abort_cen",   bus.usb_cen_o, 1);
        chk("abort_drive", bus.usb_drive_o, 0);
        chk("abort_rspv",  bus.rsp_valid_o, 0);
        chk("abort_ready", bus.cmd_ready_o, 0);
        chk("abort_rdata", bus.rsp_rdata_o, 0);
        #2 reset_i = 1'b0;
        offer(1'b0, 21'h0002A, 8'h00);
        bus.usb_din_i = 8'h6E;
        exp_q.push_back(8'h6E);
        #1;
        chk("post_rst_ready", bus.cmd_ready_o, 1);
        tick();
        bus.cmd_valid_i = 1'b0;
        chk("post_rst_accept_cen", bus.usb_cen_o, 0);
        chk("post_rst_addr", bus.usb_addr_o, 21'h0002A);
        wait_rsp("post_rst_latency");
        exp_b = exp_q.pop_front();
        chk("post_rst_rdata", bus.rsp_rdata_o, exp_b);
        tick();

`ifdef USB_MASTER_TRIGGER_EN
        // ---- trigger on a write, none on a read ----
        chk("trig_idle", bus.usb_trigger_o, 0);
        offer(1'b1, 21'h00010, 8'h77);
        bus.cmd_trig_i = 1'b1;
        tick();
        bus.cmd_valid_i = 1'b0;
        bus.cmd_trig_i  = 1'b0;
        chk("trig_wr_setup", bus.usb_trigger_o, 0);
        tick();
        chk("trig_wr_strobe1", bus.usb_trigger_o, 1);
        tick();
        chk("trig_wr_strobe2", bus.usb_trigger_o, 1);
        tick();
        chk("trig_wr_hold", bus.usb_trigger_o, 0);
        tick();
        chk("trig_wr_rspv", bus.rsp_valid_o, 1);
        offer(1'b0, 21'h00011, 8'h00);
        bus.cmd_trig_i = 1'b1;
        tick();
        bus.cmd_valid_i = 1'b0;
        bus.cmd_trig_i  = 1'b0;
        tick();
        chk("trig_rd_strobe1", bus.usb_trigger_o, 0);
        tick();
        chk("trig_rd_strobe2", bus.usb_trigger_o, 0);
        tick();
        tick();
        chk("trig_rd_rspv", bus.rsp_valid_o, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
